// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encoding and a
// constant-width helper.
package btn_debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_RISE_CHK = 2'd1,
      S_HIGH     = 2'd2,
      S_FALL_CHK = 2'd3
   } state_t;

   // Ceiling log2 for sizing counters at elaboration time.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((longint'(1) << r) < longint'(v)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
// Shared by the board input blocks (buttons, switches, UART rx).
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) sr <= '0;
      else     sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: synchronise, debounce, emit level/edge strobes and a
// press counter. Define BTN_LONG_PRESS_EN to enable the long-press strobe.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_in,
   output logic             btn_level,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             long_pulse,
   output logic [CNT_W-1:0] press_cnt
);

   localparam int unsigned DB_W = clog2(DEBOUNCE_CYCLES + 1);

   logic            btn_s;
   state_t          state;
   logic [DB_W-1:0] db_cnt;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (btn_s)
   );

   // A change is committed only after btn_s has held for DEBOUNCE_CYCLES checks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_LOW;
         db_cnt     <= '0;
         btn_level  <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         press_cnt  <= '0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            S_LOW: begin
               if (btn_s) begin
                  state  <= S_RISE_CHK;
                  db_cnt <= DB_W'(1);
               end
            end
            S_RISE_CHK: begin
               if (!btn_s) begin
                  state  <= S_LOW;
                  db_cnt <= '0;
               end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                  state      <= S_HIGH;
                  db_cnt     <= '0;
                  btn_level  <= 1'b1;
                  rise_pulse <= 1'b1;
                  press_cnt  <= press_cnt + CNT_W'(1);
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            S_HIGH: begin
               if (!btn_s) begin
                  state  <= S_FALL_CHK;
                  db_cnt <= DB_W'(1);
               end
            end
            S_FALL_CHK: begin
               if (btn_s) begin
                  state  <= S_HIGH;
                  db_cnt <= '0;
               end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                  state      <= S_LOW;
                  db_cnt     <= '0;
                  btn_level  <= 1'b0;
                  fall_pulse <= 1'b1;
               end else begin
                  db_cnt <= db_cnt + DB_W'(1);
               end
            end
            default: state <= S_LOW;
         endcase
      end
   end

`ifdef BTN_LONG_PRESS_EN
   localparam int unsigned HOLD_W = clog2(LONG_CYCLES + 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic              long_done;

   // long_done suppresses a second strobe when a release bounces back to S_HIGH.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt   <= '0;
         long_done  <= 1'b0;
         long_pulse <= 1'b0;
      end else begin
         long_pulse <= 1'b0;
         if (state == S_HIGH) begin
            if (!btn_s) begin
               hold_cnt <= '0;
            end else begin
               if (hold_cnt != HOLD_W'(LONG_CYCLES)) hold_cnt <= hold_cnt + HOLD_W'(1);
               if (hold_cnt == HOLD_W'(LONG_CYCLES - 1) && !long_done) begin
                  long_pulse <= 1'b1;
                  long_done  <= 1'b1;
               end
            end
         end else if (state == S_LOW) begin
            long_done <= 1'b0;
         end
      end
   end
`else
   localparam logic LONG_OK = (LONG_CYCLES >= 1);

   assign long_pulse = 1'b0 & LONG_OK;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=8, giving an 11-edge
// commit latency; long-press checks follow BTN_LONG_PRESS_EN.
module tb_btn_debounce;

   localparam int unsigned CNT_W = 2;
`ifdef BTN_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             btn_in = 1'b0;
   logic             btn_level;
   logic             rise_pulse;
   logic             fall_pulse;
   logic             long_pulse;
   logic [CNT_W-1:0] press_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   btn_debounce #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8),
      .LONG_CYCLES     (20),
      .CNT_W           (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .long_pulse (long_pulse),
      .press_cnt  (press_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      btn_in = 1'b0;
      tick(); tick(); tick();
      tests_run += 5;
      if (btn_level !== 1'b0) begin tests_failed++; $display("FAIL reset_level got=%b exp=0", btn_level); end
      if (rise_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_rise got=%b exp=0", rise_pulse); end
      if (fall_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_fall got=%b exp=0", fall_pulse); end
      if (long_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_long got=%b exp=0", long_pulse); end
      if (press_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_cnt got=%0d exp=0", press_cnt); end
      rst = 1'b0;
      tick();
   endtask

   // High 5, low 1, high 3, then low: both runs are shorter than the threshold.
   task automatic test_bounce();
      for (int i = 0; i < 30; i++) begin
         btn_in = (i < 5) || (i >= 6 && i < 9);
         tick();
         tests_run += 2;
         if (btn_level !== 1'b0) begin tests_failed++; $display("FAIL bounce_level cyc=%0d got=%b exp=0", i, btn_level); end
         if (rise_pulse !== 1'b0) begin tests_failed++; $display("FAIL bounce_rise cyc=%0d got=%b exp=0", i, rise_pulse); end
      end
      tests_run++;
      if (press_cnt !== 2'd0) begin tests_failed++; $display("FAIL bounce_cnt got=%0d exp=0", press_cnt); end
   endtask

   task automatic test_clean_press();
      btn_in = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         tests_run += 3;
         if (btn_level !== (e >= 11)) begin tests_failed++; $display("FAIL press_level edge=%0d got=%b exp=%b", e, btn_level, e >= 11); end
         if (rise_pulse !== (e == 11)) begin tests_failed++; $display("FAIL press_rise edge=%0d got=%b exp=%b", e, rise_pulse, e == 11); end
         if (fall_pulse !== 1'b0) begin tests_failed++; $display("FAIL press_fall edge=%0d got=%b exp=0", e, fall_pulse); end
      end
      tests_run++;
      if (press_cnt !== 2'd1) begin tests_failed++; $display("FAIL press_cnt got=%0d exp=1", press_cnt); end
   endtask

   task automatic test_release();
      btn_in = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         tests_run += 3;
         if (btn_level !== (e < 11)) begin tests_failed++; $display("FAIL release_level edge=%0d got=%b exp=%b", e, btn_level, e < 11); end
         if (fall_pulse !== (e == 11)) begin tests_failed++; $display("FAIL release_fall edge=%0d got=%b exp=%b", e, fall_pulse, e == 11); end
         if (rise_pulse !== 1'b0) begin tests_failed++; $display("FAIL release_rise edge=%0d got=%b exp=0", e, rise_pulse); end
      end
      tests_run++;
      if (press_cnt !== 2'd1) begin tests_failed++; $display("FAIL release_cnt got=%0d exp=1", press_cnt); end
   endtask

   // Reset lands on edge 6 of a press (press_cnt is 1 beforehand); button stays held.
   task automatic test_reset_mid();
      btn_in = 1'b1;
      for (int e = 1; e <= 5; e++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run += 4;
      if (btn_level !== 1'b0) begin tests_failed++; $display("FAIL rstmid_level got=%b exp=0", btn_level); end
      if (rise_pulse !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rise got=%b exp=0", rise_pulse); end
      if (fall_pulse !== 1'b0) begin tests_failed++; $display("FAIL rstmid_fall got=%b exp=0", fall_pulse); end
      if (press_cnt !== 2'd0) begin tests_failed++; $display("FAIL rstmid_cnt got=%0d exp=0", press_cnt); end
      for (int e = 1; e <= 12; e++) begin
         tick();
         tests_run += 2;
         if (btn_level !== (e >= 11)) begin tests_failed++; $display("FAIL rstmid_relevel edge=%0d got=%b exp=%b", e, btn_level, e >= 11); end
         if (rise_pulse !== (e == 11)) begin tests_failed++; $display("FAIL rstmid_rerise edge=%0d got=%b exp=%b", e, rise_pulse, e == 11); end
      end
      tests_run++;
      if (press_cnt !== 2'd1) begin tests_failed++; $display("FAIL rstmid_recnt got=%0d exp=1", press_cnt); end
      btn_in = 1'b0;
      for (int e = 1; e <= 12; e++) tick();
   endtask

   task automatic test_wrap();
      logic [CNT_W-1:0] exp_cnt [4];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int p = 0; p < 4; p++) begin
         btn_in = 1'b1;
         for (int e = 1; e <= 12; e++) tick();
         tests_run += 2;
         if (press_cnt !== exp_cnt[p]) begin tests_failed++; $display("FAIL wrap_cnt press=%0d got=%0d exp=%0d", p, press_cnt, exp_cnt[p]); end
         if (btn_level !== 1'b1) begin tests_failed++; $display("FAIL wrap_level press=%0d got=%b exp=1", p, btn_level); end
         btn_in = 1'b0;
         for (int e = 1; e <= 12; e++) tick();
      end
   endtask

   // Rise at edge 11; with the feature on, long_pulse at edge 31 only.
   task automatic test_long_press();
      int n_long;
      n_long = 0;
      btn_in = 1'b1;
      for (int e = 1; e <= 50; e++) begin
         tick();
         if (long_pulse === 1'b1) n_long++;
         tests_run += 2;
         if (rise_pulse !== (e == 11)) begin tests_failed++; $display("FAIL long_rise edge=%0d got=%b exp=%b", e, rise_pulse, e == 11); end
         if (long_pulse !== (LONG_EN && e == 31)) begin tests_failed++; $display("FAIL long_pulse edge=%0d got=%b exp=%b", e, long_pulse, LONG_EN && e == 31); end
      end
      btn_in = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (long_pulse === 1'b1) n_long++;
         tests_run += 2;
         if (long_pulse !== 1'b0) begin tests_failed++; $display("FAIL long_after_release edge=%0d got=%b exp=0", e, long_pulse); end
         if (fall_pulse !== (e == 11)) begin tests_failed++; $display("FAIL long_fall edge=%0d got=%b exp=%b", e, fall_pulse, e == 11); end
      end
      tests_run++;
      if (n_long !== (LONG_EN ? 1 : 0)) begin tests_failed++; $display("FAIL long_count got=%0d exp=%0d", n_long, LONG_EN ? 1 : 0); end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_clean_press();
      test_release();
      test_reset_mid();
      test_wrap();
      test_long_press();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
